// File: rtl/cnn_bn_pkg.sv
// Shared constants and load-phase encoding for the batch-norm fold + ReLU stage.
package cnn_bn_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int FRAC_BITS_DEF  = 16;

    localparam logic signed [DATA_WIDTH_DEF-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};
    localparam logic signed [DATA_WIDTH_DEF-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        LOAD_SCALE = 2'd0,
        LOAD_BIAS  = 2'd1,
        READY      = 2'd2
    } load_phase_e;

endpackage

// File: rtl/cnn_bn_relu_64ch_param_ram.sv
// Per-channel scale and bias storage: one write port fed by the load counter,
// one read port indexed by channel whose data is captured in the first pipeline stage.
module bn_param_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHANNEL_NUM = 64
) (
    input  logic                           clk,
    input  logic                           wr_scale_i,
    input  logic                           wr_bias_i,
    input  logic [$clog2(CHANNEL_NUM)-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic [$clog2(CHANNEL_NUM)-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0]          rd_scale_o,
    output logic [DATA_WIDTH-1:0]          rd_bias_o
);

    logic [DATA_WIDTH-1:0] scale_mem [CHANNEL_NUM];
    logic [DATA_WIDTH-1:0] bias_mem  [CHANNEL_NUM];

    // Contents survive reset; only a reload rewrites them.
    always_ff @(posedge clk) begin
        if (wr_scale_i) scale_mem[wr_addr_i] <= wr_data_i;
        if (wr_bias_i)  bias_mem[wr_addr_i]  <= wr_data_i;
    end

    assign rd_scale_o = scale_mem[rd_addr_i];
    assign rd_bias_o  = bias_mem[rd_addr_i];

endmodule

// File: rtl/cnn_bn_relu_64ch.sv
// Per-channel y = sat(scale[c]*x + bias[c]) followed by ReLU, 3-cycle latency.
// Define BN_RELU_EN to clamp negative results to zero; otherwise S3 passes the saturated value.
module cnn_bn_relu_64ch
    import cnn_bn_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int FRAC_BITS    = FRAC_BITS_DEF,
    parameter int IMAGE_WIDTH  = 612,
    parameter int IMAGE_HEIGHT = 612,
    parameter int CHANNEL_NUM  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_weight_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic [1:0]            load_phase_o
);

    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int PIX_W      = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int CH_W       = $clog2(CHANNEL_NUM);
    localparam int DW         = DATA_WIDTH;

    localparam logic signed [2*DW-1:0] SH_MAX  = {{DW{1'b0}}, {DW{1'b1}}};
    localparam logic signed [2*DW-1:0] SH_MIN  = {{DW{1'b1}}, {DW{1'b0}}};
    localparam logic signed [DW+1:0]   SUM_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0]   SUM_MIN = {3'b111, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] OUT_MAX = (DW == DATA_WIDTH_DEF) ? DW'(SAT_MAX) : {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] OUT_MIN = (DW == DATA_WIDTH_DEF) ? DW'(SAT_MIN) : {1'b1, {(DW-1){1'b0}}};

    // No backpressure: a word is taken on every cycle its valid is high; valid_out
    // mirrors accepted valid_in three cycles later, gaps included.
    load_phase_e       phase_q, phase_d;
    logic [CH_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
    logic              wr_scale, wr_bias, reload, accept;
    logic [DW-1:0]     rd_scale, rd_bias;

    always_comb begin
        phase_d  = phase_q;
        ld_cnt_d = ld_cnt_q;
        wr_scale = 1'b0;
        wr_bias  = 1'b0;
        reload   = 1'b0;
        if (valid_weight_in) begin
            unique case (phase_q)
                LOAD_SCALE: begin
                    wr_scale = 1'b1;
                    if (ld_cnt_q == CH_W'(CHANNEL_NUM - 1)) begin
                        ld_cnt_d = '0;
                        phase_d  = LOAD_BIAS;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
                LOAD_BIAS: begin
                    wr_bias = 1'b1;
                    if (ld_cnt_q == CH_W'(CHANNEL_NUM - 1)) begin
                        ld_cnt_d = '0;
                        phase_d  = READY;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
                READY: begin
                    // ld_cnt_q is zero here, so this word lands in scale[0].
                    wr_scale = 1'b1;
                    reload   = 1'b1;
                    ld_cnt_d = CH_W'(1);
                    phase_d  = LOAD_SCALE;
                end
                default: phase_d = LOAD_SCALE;
            endcase
        end
    end

    assign accept = valid_in && (phase_q == READY) && !valid_weight_in;

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        ch_cnt_d  = ch_cnt_q;
        if (reload) begin
            pix_cnt_d = '0;
            ch_cnt_d  = '0;
        end else if (accept) begin
            if (pix_cnt_q == PIX_W'(IMAGE_SIZE - 1)) begin
                pix_cnt_d = '0;
                ch_cnt_d  = (ch_cnt_q == CH_W'(CHANNEL_NUM - 1)) ? '0 : ch_cnt_q + 1'b1;
            end else begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= LOAD_SCALE;
            ld_cnt_q  <= '0;
            pix_cnt_q <= '0;
            ch_cnt_q  <= '0;
        end else begin
            phase_q   <= phase_d;
            ld_cnt_q  <= ld_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            ch_cnt_q  <= ch_cnt_d;
        end
    end

    assign load_phase_o = phase_q;

    bn_param_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHANNEL_NUM(CHANNEL_NUM)
    ) u_param_ram (
        .clk       (clk),
        .wr_scale_i(wr_scale),
        .wr_bias_i (wr_bias),
        .wr_addr_i (ld_cnt_q),
        .wr_data_i (weight_in),
        .rd_addr_i (ch_cnt_q),
        .rd_scale_o(rd_scale),
        .rd_bias_o (rd_bias)
    );

    logic signed [2*DW-1:0] pxl_ext, scale_ext, prod_q, shifted;
    logic [DW-1:0]          bias1_q, sat, sat_q, relu;
    logic [DW:0]            shifted_cl;
    logic signed [DW+1:0]   sum;
    logic                   valid1_q, valid2_q;

    assign pxl_ext   = {{DW{pxl_in[DW-1]}}, pxl_in};
    assign scale_ext = {{DW{rd_scale[DW-1]}}, rd_scale};

    // Clamp the shifted product to DW+1 bits first so the DW+2-bit add cannot wrap.
    always_comb begin
        shifted = prod_q >>> FRAC_BITS;
        if (shifted > SH_MAX)      shifted_cl = SH_MAX[DW:0];
        else if (shifted < SH_MIN) shifted_cl = SH_MIN[DW:0];
        else                       shifted_cl = shifted[DW:0];
        sum = $signed({shifted_cl[DW], shifted_cl}) + $signed({{2{bias1_q[DW-1]}}, bias1_q});
        if (sum > SUM_MAX)      sat = OUT_MAX;
        else if (sum < SUM_MIN) sat = OUT_MIN;
        else                    sat = sum[DW-1:0];
    end

`ifdef BN_RELU_EN
    assign relu = sat_q[DW-1] ? '0 : sat_q;
`else
    assign relu = sat_q;
`endif

    always_ff @(posedge clk) begin
        prod_q  <= pxl_ext * scale_ext;
        bias1_q <= rd_bias;
        sat_q   <= sat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid1_q  <= 1'b0;
            valid2_q  <= 1'b0;
            valid_out <= 1'b0;
            pxl_out   <= '0;
        end else begin
            valid1_q  <= accept;
            valid2_q  <= valid1_q;
            valid_out <= valid2_q;
            pxl_out   <= relu;
        end
    end

endmodule

// File: tb/tb_cnn_bn_relu_64ch.sv
// Directed bench for cnn_bn_relu_64ch with a 2x2 image so channel planes are 4 pixels long.
module tb_cnn_bn_relu_64ch;
    import cnn_bn_pkg::*;

    localparam int DW    = 32;
    localparam int NCH   = 64;
    localparam int PLANE = 4;
`ifdef BN_RELU_EN
    localparam bit RELU_ON = 1'b1;
`else
    localparam bit RELU_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in, valid_weight_in, valid_out;
    logic [DW-1:0] pxl_in, weight_in, pxl_out;
    logic [1:0]    load_phase;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] exp_q[$];
    int            exp_t_q[$];
    logic [DW-1:0] sc[NCH];
    logic [DW-1:0] bi[NCH];
    logic [DW-1:0] tab[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cnn_bn_relu_64ch #(
        .IMAGE_WIDTH (2),
        .IMAGE_HEIGHT(2),
        .CHANNEL_NUM (NCH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .pxl_in         (pxl_in),
        .valid_weight_in(valid_weight_in),
        .weight_in      (weight_in),
        .pxl_out        (pxl_out),
        .valid_out      (valid_out),
        .load_phase_o   (load_phase)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: every valid_out must match the oldest expected pixel, 3 cycles after it was sent.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid_out", {31'b0, valid_out}, 32'd0);
            end else begin
                logic [DW-1:0] e;
                int            t;
                e = exp_q.pop_front();
                t = exp_t_q.pop_front();
                check("pxl_out", pxl_out, e);
                check("latency", 32'(cyc - t), 32'd3);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic keep, input logic [DW-1:0] e);
        valid_in = 1'b1;
        pxl_in   = d;
        if (keep) begin
            exp_q.push_back(e);
            exp_t_q.push_back(cyc);
        end
        tick();
        valid_in = 1'b0;
    endtask

    task automatic load(input logic noisy);
        for (int i = 0; i < 2 * NCH; i++) begin
            valid_weight_in = 1'b1;
            weight_in       = (i < NCH) ? sc[i] : bi[i - NCH];
            if (noisy) begin
                valid_in = 1'($urandom_range(0, 1));
                pxl_in   = $urandom;
            end
            tick();
            if (i == 0) check("phase_after_first_word", {30'b0, load_phase}, {30'b0, LOAD_SCALE});
        end
        valid_weight_in = 1'b0;
        valid_in        = 1'b0;
        check("phase_loaded", {30'b0, load_phase}, {30'b0, READY});
    endtask

    initial begin
        reset           = 1'b1;
        valid_in        = 1'b0;
        pxl_in          = '0;
        valid_weight_in = 1'b0;
        weight_in       = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_valid_out", {31'b0, valid_out}, 32'd0);
        check("reset_pxl_out", pxl_out, 32'd0);
        check("reset_phase", {30'b0, load_phase}, {30'b0, LOAD_SCALE});

        // Pixels before any load are dropped.
        for (int i = 0; i < 10; i++) send($urandom, 1'b0, '0);

        // scale = 1.0, bias[c] = -c
        for (int c = 0; c < NCH; c++) begin
            sc[c] = 32'h0001_0000;
            bi[c] = 32'(-(c * 65536));
        end
        load(1'b0);
        tab[0] = 32'h0002_0000;
        tab[1] = 32'h0001_0000;
        tab[2] = 32'h0000_0000;
        tab[3] = RELU_ON ? 32'h0000_0000 : 32'hFFFF_0000;
        for (int c = 0; c < 4; c++)
            for (int p = 0; p < PLANE; p++) send(32'h0002_0000, 1'b1, tab[c]);

        // 64.0 - c stays positive for every channel, so channel wrap 63 -> 0 is visible.
        for (int k = 4; k < NCH + 5; k++)
            for (int p = 0; p < PLANE; p++) send(32'h0040_0000, 1'b1, (32'(NCH - (k % NCH))) << 16);

        // Two pixels into ch5, then reload mid-plane with noisy pixels during the load.
        send(32'h0040_0000, 1'b1, 32'h003B_0000);
        send(32'h0040_0000, 1'b1, 32'h003B_0000);
        for (int c = 0; c < NCH; c++) begin
            sc[c] = 32'h7FFF_FFFF;
            bi[c] = 32'h0000_0000;
        end
        sc[1] = 32'h0000_8000;
        sc[2] = 32'h0001_0000;
        bi[2] = 32'h7FFF_FFFF;
        load(1'b1);

        // ch0: scale ~32768.0, saturation both ways
        send(32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF);
        send(32'h8000_0000, 1'b1, RELU_ON ? 32'h0 : 32'h8000_0000);
        send(32'h0003_0000, 1'b1, 32'h7FFF_FFFF);
        send(32'hFFFF_0000, 1'b1, RELU_ON ? 32'h0 : 32'h8000_0001);
        // ch1: scale 0.5, shift truncates toward -inf
        send(32'h0000_0003, 1'b1, 32'h0000_0001);
        send(32'hFFFF_FFFD, 1'b1, RELU_ON ? 32'h0 : 32'hFFFF_FFFE);
        send(32'h0002_0000, 1'b1, 32'h0001_0000);
        send(32'h7FFF_FFFF, 1'b1, 32'h3FFF_FFFF);
        // ch2: bias-driven saturation
        send(32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF);
        send(32'h8000_0000, 1'b1, RELU_ON ? 32'h0 : 32'hFFFF_FFFF);
        repeat (4) tick();

        // Reset with pixels in flight: nothing may come out afterwards.
        send(32'h0001_0000, 1'b0, '0);
        send(32'h0001_0000, 1'b0, '0);
        valid_in = 1'b1;
        pxl_in   = 32'h0001_0000;
        reset    = 1'b1;
        tick();
        valid_in = 1'b0;
        reset    = 1'b0;
        check("midrst_valid_out", {31'b0, valid_out}, 32'd0);
        check("midrst_pxl_out", pxl_out, 32'd0);
        check("midrst_phase", {30'b0, load_phase}, {30'b0, LOAD_SCALE});
        for (int i = 0; i < 5; i++) send(32'h0001_0000, 1'b0, '0);
        repeat (5) tick();

        // Identity parameters, two planes of non-negative pixels with gaps.
        for (int c = 0; c < NCH; c++) begin
            sc[c] = 32'h0001_0000;
            bi[c] = 32'h0000_0000;
        end
        load(1'b0);
        for (int i = 0; i < 2 * PLANE; i++) begin
            logic [DW-1:0] d;
            d = $urandom & 32'h7FFF_FFFF;
            send(d, 1'b1, d);
            if (i % 3 == 2) tick();
        end

        repeat (6) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
